// File: rtl/sd_rsp_rx.sv
// SD card 48-bit command-response receiver: waits (bounded) for a start bit on CMD,
// shifts in the frame, checks CRC7 plus transmission/end bits, and reports the fields.
module sd_rsp_rx #(
  parameter int TIMEOUT = 64
) (
  input  logic        sdClk,
  input  logic        rspRst,
  input  logic        cmdIn,
  input  logic        rxEn,
  output logic        busy,
  output logic [5:0]  rspIdx,
  output logic [31:0] rspArg,
  output logic [6:0]  rspCrc,
  output logic        rspDone,
  output logic        crcErr,
  output logic        frmErr,
  output logic        timeoutErr
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [5:0] LAST_CRC_BIT   = 6'd39;
  localparam logic [5:0] LAST_FIELD_BIT = 6'd46;
  localparam logic [5:0] END_BIT        = 6'd47;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    RX         = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [5:0]       bit_cnt_r;
  logic [6:0]       crc_r;
  logic [6:0]       crc_field_r;
  // Frame bits 1..39; bit 0 is the start bit and always 0, so it is not kept.
  logic [38:0]      shift_r;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Single FSM: capture datapath and all registered outputs.
  always_ff @(posedge sdClk) begin
    if (rspRst) begin
      state_r     <= IDLE;
      wait_cnt_r  <= '0;
      bit_cnt_r   <= 6'd0;
      crc_r       <= 7'h00;
      crc_field_r <= 7'h00;
      shift_r     <= 39'd0;
      busy        <= 1'b0;
      rspIdx      <= 6'd0;
      rspArg      <= 32'd0;
      rspCrc      <= 7'h00;
      rspDone     <= 1'b0;
      crcErr      <= 1'b0;
      frmErr      <= 1'b0;
      timeoutErr  <= 1'b0;
    end else begin
      rspDone <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rxEn) begin
            state_r    <= WAIT_START;
            busy       <= 1'b1;
            wait_cnt_r <= '0;
            crc_r      <= 7'h00;
            crcErr     <= 1'b0;
            frmErr     <= 1'b0;
            timeoutErr <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end

        // A start bit on the final allowed sample still wins over the timeout.
        WAIT_START: begin
          if (!cmdIn) begin
            state_r   <= RX;
            bit_cnt_r <= 6'd1;
            crc_r     <= crc7_step(crc_r, 1'b0);
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r    <= DONE;
            timeoutErr <= 1'b1;
            rspDone    <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1'b1);
          end
        end

        RX: begin
          if (bit_cnt_r <= LAST_CRC_BIT) begin
            crc_r   <= crc7_step(crc_r, cmdIn);
            shift_r <= {shift_r[37:0], cmdIn};
          end else if (bit_cnt_r <= LAST_FIELD_BIT) begin
            crc_field_r <= {crc_field_r[5:0], cmdIn};
          end else begin
            crc_field_r <= crc_field_r;
          end

          if (bit_cnt_r == END_BIT) begin
            state_r <= DONE;
            rspIdx  <= shift_r[37:32];
            rspArg  <= shift_r[31:0];
            rspCrc  <= crc_field_r;
            crcErr  <= (crc_r != crc_field_r);
            frmErr  <= shift_r[38] | ~cmdIn;
            rspDone <= 1'b1;
          end else begin
            bit_cnt_r <= bit_cnt_r + 6'd1;
          end
        end

        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_rsp_rx.sv
// Self-checking bench for sd_rsp_rx: table of response frames plus hand sequences for
// timeout, start-on-last-cycle, mid-frame reset, reset/arm priority and ignored re-arm.
module tb_sd_rsp_rx;

  localparam int TO = 64;

  logic        sdClk = 1'b0;
  logic        rspRst, cmdIn, rxEn;
  logic        busy, rspDone, crcErr, frmErr, timeoutErr;
  logic [5:0]  rspIdx;
  logic [31:0] rspArg;
  logic [6:0]  rspCrc;

  sd_rsp_rx #(.TIMEOUT(TO)) dut (
    .sdClk(sdClk), .rspRst(rspRst), .cmdIn(cmdIn), .rxEn(rxEn), .busy(busy),
    .rspIdx(rspIdx), .rspArg(rspArg), .rspCrc(rspCrc), .rspDone(rspDone),
    .crcErr(crcErr), .frmErr(frmErr), .timeoutErr(timeoutErr)
  );

  always #5 sdClk = ~sdClk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        crc_err;
    logic        frm_err;
    logic        to_err;
  } exp_t;

  typedef struct {
    logic [39:0] hdr;
    logic [6:0]  crcf;      // literal CRC field, or XOR mask on the computed CRC when use_calc
    logic        endb;
    logic        use_calc;
    int          idle;
    logic        exp_crc;
    logic        exp_frm;
  } vec_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [5:0]  last_idx = 6'd0;
  logic [31:0] last_arg = 32'd0;
  logic [6:0]  last_crc = 7'h00;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  // Scoreboard: every rspDone pulse consumes one expected result.
  always @(negedge sdClk) begin
    exp_t e;
    if (rspDone) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got rspDone=1, expected no pulse");
      end else begin
        e = sb.pop_front();
        chk("rspIdx", rspIdx, e.idx);
        chk("rspArg", rspArg, e.arg);
        chk("rspCrc", rspCrc, e.crc);
        chk("crcErr", crcErr, e.crc_err);
        chk("frmErr", frmErr, e.frm_err);
        chk("timeoutErr", timeoutErr, e.to_err);
      end
    end
  end

  task automatic run_frame(input logic [47:0] frame, input int idle,
                           input logic exp_crc, input logic exp_frm, input int pulse_at);
    exp_t e;
    e.idx = frame[45:40];
    e.arg = frame[39:8];
    e.crc = frame[7:1];
    e.crc_err = exp_crc;
    e.frm_err = exp_frm;
    e.to_err  = 1'b0;
    sb.push_back(e);
    last_idx = e.idx;
    last_arg = e.arg;
    last_crc = e.crc;
    @(negedge sdClk); rxEn = 1'b1; cmdIn = 1'b1;
    @(negedge sdClk); rxEn = 1'b0;
    chk("busy_armed", busy, 1'b1);
    repeat (idle) begin cmdIn = 1'b1; @(negedge sdClk); end
    for (int b = 47; b >= 0; b--) begin
      cmdIn = frame[b];
      rxEn  = ((47 - b) == pulse_at);
      @(negedge sdClk);
    end
    rxEn = 1'b0; cmdIn = 1'b1;
    chk("done_latency", rspDone, 1'b1);
    @(negedge sdClk);
    chk("done_width", rspDone, 1'b0);
    chk("busy_release", busy, 1'b0);
  endtask

  vec_t        vecs[9];
  logic [47:0] f;
  logic [6:0]  cf;

  initial begin
    rspRst = 1'b1; cmdIn = 1'b1; rxEn = 1'b0;
    repeat (3) @(negedge sdClk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", rspDone, 1'b0);
    chk("rst_idx", rspIdx, 6'd0);
    chk("rst_arg", rspArg, 32'd0);
    chk("rst_flags", {crcErr, frmErr, timeoutErr}, 3'b000);
    rspRst = 1'b0;

    vecs[0] = '{40'h00_0000_0000, 7'h00, 1'b1, 1'b0, 3,  1'b0, 1'b0};
    vecs[1] = '{40'h48_0000_01AA, 7'h43, 1'b1, 1'b0, 1,  1'b0, 1'b1};
    vecs[2] = '{40'h40_0000_0000, 7'h4B, 1'b1, 1'b0, 0,  1'b1, 1'b1};
    vecs[3] = '{40'h40_0000_0000, 7'h4A, 1'b1, 1'b0, 2,  1'b0, 1'b1};
    vecs[4] = '{40'h11_0000_0900, 7'h00, 1'b1, 1'b1, 5,  1'b0, 1'b0};
    vecs[5] = '{40'h0D_0000_0900, 7'h01, 1'b1, 1'b1, 1,  1'b1, 1'b0};
    vecs[6] = '{40'h00_0000_0000, 7'h00, 1'b0, 1'b0, 0,  1'b0, 1'b1};
    vecs[7] = '{40'h3F_FFFF_FFFF, 7'h00, 1'b1, 1'b1, 4,  1'b0, 1'b0};
    vecs[8] = '{40'h2A_5A5A_5A5A, 7'h40, 1'b0, 1'b1, 2,  1'b1, 1'b1};

    foreach (vecs[i]) begin
      cf = vecs[i].use_calc ? (crc7(vecs[i].hdr) ^ vecs[i].crcf) : vecs[i].crcf;
      f  = {vecs[i].hdr, cf, vecs[i].endb};
      run_frame(f, vecs[i].idle, vecs[i].exp_crc, vecs[i].exp_frm, -1);
    end

    // Timeout: data fields keep the previous capture.
    begin
      exp_t e;
      e = '{last_idx, last_arg, last_crc, 1'b0, 1'b0, 1'b1};
      sb.push_back(e);
      @(negedge sdClk); rxEn = 1'b1; cmdIn = 1'b1;
      @(negedge sdClk); rxEn = 1'b0;
      for (int i = 0; i < TO; i++) begin
        if (i == TO - 1) chk("no_early_timeout", rspDone, 1'b0);
        cmdIn = 1'b1;
        @(negedge sdClk);
      end
      chk("timeout_done", rspDone, 1'b1);
      @(negedge sdClk);
      chk("timeout_busy_low", busy, 1'b0);
      chk("timeout_flag_held", timeoutErr, 1'b1);
    end

    // Start bit on exactly the last allowed cycle, then a valid frame.
    f = {40'h08_0000_01AA, crc7(40'h08_0000_01AA), 1'b1};
    run_frame(f, TO - 1, 1'b0, 1'b0, -1);
    chk("start_at_limit_no_to", timeoutErr, 1'b0);

    // Re-arm pulse mid-RX is ignored.
    f = {40'h11_1234_5678, crc7(40'h11_1234_5678), 1'b1};
    run_frame(f, 2, 1'b0, 1'b0, 10);
    repeat (3) @(negedge sdClk);
    chk("rearm_ignored_busy", busy, 1'b0);

    // Reset at frame bit 20 discards the partial frame.
    f = {40'h3A_DEAD_BEEF, crc7(40'h3A_DEAD_BEEF), 1'b1};
    @(negedge sdClk); rxEn = 1'b1; cmdIn = 1'b1;
    @(negedge sdClk); rxEn = 1'b0;
    for (int b = 47; b >= 28; b--) begin cmdIn = f[b]; @(negedge sdClk); end
    cmdIn = f[27]; rspRst = 1'b1;
    @(negedge sdClk); rspRst = 1'b0; cmdIn = 1'b1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_arg", rspArg, 32'd0);
    chk("midrst_idx", rspIdx, 6'd0);
    last_idx = 6'd0; last_arg = 32'd0; last_crc = 7'h00;
    for (int b = 26; b >= 0; b--) begin cmdIn = f[b]; @(negedge sdClk); end
    cmdIn = 1'b1;
    repeat (4) @(negedge sdClk);
    chk("midrst_stays_idle", busy, 1'b0);
    run_frame(48'h0000_0000_0001, 3, 1'b0, 1'b0, -1);

    // Reset beats a simultaneous arm.
    @(negedge sdClk); rspRst = 1'b1; rxEn = 1'b1;
    @(negedge sdClk); rspRst = 1'b0; rxEn = 1'b0;
    chk("rst_over_arm_busy", busy, 1'b0);
    @(negedge sdClk);
    chk("rst_over_arm_idle", busy, 1'b0);

    repeat (3) @(negedge sdClk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
